issue_queue: RTL and testbench

Parametrised centralized issue queue with per-channel oldest-first select, placed between rename/dispatch and the execution units. It holds up to DEPTH renamed micro-ops and tracks source-operand readiness through writeback tag broadcast. Each cycle it issues, to each of NUM_FU functional-unit channels, the oldest ready entry of that channel's FU class. It replaces fixed four-arbiter issue logic with configurable depth, channel count, channel class mapping, back-pressure and flush.

---
 rtl/iq_pkg.sv | 25 ++
 rtl/iq_age_select.sv | 25 ++
 rtl/issue_queue.sv | 244 ++++++++++++++++++++++++
 tb/tb_issue_queue.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
// Shared constants and types for the centralized issue queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the FU class encoding, the default channel-to-class map and the
// per-entry status struct. Opcode and tag widths are parameters of the queue,
// so those payload fields live in parallel arrays next to this struct.
package iq_pkg;

    localparam logic [1:0] FU_ALU = 2'd0;
    localparam logic [1:0] FU_MUL = 2'd1;
    localparam logic [1:0] FU_LS  = 2'd2;
    localparam logic [1:0] FU_BR  = 2'd3;

    // ch0=ALU, ch1=ALU, ch2=MUL, ch3=LS; channel c occupies bits [2c+1:2c]
    localparam logic [7:0] FU_CLASS_DEFAULT = {FU_LS, FU_MUL, FU_ALU, FU_ALU};

    typedef struct packed {
        logic       valid;
        logic [1:0] fu;
        logic       src0_rdy;
        logic       src1_rdy;
    } iq_entry_t;

endpackage

// File: rtl/iq_age_select.sv
// Oldest-first one-hot select over an age matrix.
// Latency: combinational.
// Backpressure: none; callers mask the request vector.
//
// Ports: req (request per entry), older (older[i][j]=1 means entry j is older
// than entry i), gnt (one-hot grant to the requester with no older requester).
module iq_age_select
    import iq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic [DEPTH-1:0]            req,
    input  logic [DEPTH-1:0][DEPTH-1:0] older,
    output logic [DEPTH-1:0]            gnt
);

    // The age matrix is a total order over valid entries, so exactly one
    // requester has no older requester whenever req is non-zero.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            gnt[i] = req[i] & ~(|(req & older[i]));
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Centralized issue queue: per-channel oldest-ready select with tag wakeup.
// Latency: dispatch to earliest issue 1 cycle; issue is combinational from state.
// Backpressure: disp_ready from registered count; fu_ready[c]=0 stalls channel c.
//
// Ports: clk, rst_n (async active-low), flush; dispatch disp_valid/disp_ready
// with disp_fu/op/src tags+rdy/dst tag; wakeup wb_valid/wb_tag; per-channel
// fu_ready in, iss_valid/iss_op/iss_src0_tag/iss_src1_tag/iss_dst_tag out;
// iq_count occupancy.
// Option macro IQ_SAME_CYCLE_WAKE_EN: wakeup tag matches feed eligibility in
// the same cycle instead of only through the registered rdy bits.
module issue_queue
    import iq_pkg::*;
#(
    parameter int                  DEPTH        = 16,
    parameter int                  NUM_FU       = 4,
    parameter logic [2*NUM_FU-1:0] FU_CLASS     = (2*NUM_FU)'(FU_CLASS_DEFAULT),
    parameter int                  NUM_WB       = 2,
    parameter int                  OPCODE_WIDTH = 7,
    parameter int                  PREG_WIDTH   = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           disp_valid,
    output logic                           disp_ready,
    input  logic [1:0]                     disp_fu,
    input  logic [OPCODE_WIDTH-1:0]        disp_op,
    input  logic [PREG_WIDTH-1:0]          disp_src0_tag,
    input  logic [PREG_WIDTH-1:0]          disp_src1_tag,
    input  logic                           disp_src0_rdy,
    input  logic                           disp_src1_rdy,
    input  logic [PREG_WIDTH-1:0]          disp_dst_tag,
    input  logic [NUM_WB-1:0]              wb_valid,
    input  logic [NUM_WB*PREG_WIDTH-1:0]   wb_tag,
    input  logic [NUM_FU-1:0]              fu_ready,
    output logic [NUM_FU-1:0]              iss_valid,
    output logic [NUM_FU*OPCODE_WIDTH-1:0] iss_op,
    output logic [NUM_FU*PREG_WIDTH-1:0]   iss_src0_tag,
    output logic [NUM_FU*PREG_WIDTH-1:0]   iss_src1_tag,
    output logic [NUM_FU*PREG_WIDTH-1:0]   iss_dst_tag,
    output logic [$clog2(DEPTH):0]         iq_count
);

    localparam int            CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // ------------------------------------------------------------------
    // Entry state
    // ------------------------------------------------------------------
    iq_entry_t                ent_q      [DEPTH];
    logic [OPCODE_WIDTH-1:0]  op_q       [DEPTH];
    logic [PREG_WIDTH-1:0]    src0_tag_q [DEPTH];
    logic [PREG_WIDTH-1:0]    src1_tag_q [DEPTH];
    logic [PREG_WIDTH-1:0]    dst_tag_q  [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] older_q;
    logic [CW-1:0]            count_q;

    function automatic logic wb_match(
        input logic [PREG_WIDTH-1:0]        tag,
        input logic [NUM_WB-1:0]            vld,
        input logic [NUM_WB*PREG_WIDTH-1:0] tags
    );
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < NUM_WB; w++) begin
            if (vld[w] && (tags[w*PREG_WIDTH +: PREG_WIDTH] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // ------------------------------------------------------------------
    // Wakeup matches and operand readiness used for selection
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] hit0;
    logic [DEPTH-1:0] hit1;
    logic [DEPTH-1:0] rdy0;
    logic [DEPTH-1:0] rdy1;
    logic             disp_hit0;
    logic             disp_hit1;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = ent_q[i].valid;
            hit0[i]      = wb_match(src0_tag_q[i], wb_valid, wb_tag);
            hit1[i]      = wb_match(src1_tag_q[i], wb_valid, wb_tag);
`ifdef IQ_SAME_CYCLE_WAKE_EN
            rdy0[i]      = ent_q[i].src0_rdy | hit0[i];
            rdy1[i]      = ent_q[i].src1_rdy | hit1[i];
`else
            rdy0[i]      = ent_q[i].src0_rdy;
            rdy1[i]      = ent_q[i].src1_rdy;
`endif
        end
        disp_hit0 = wb_match(disp_src0_tag, wb_valid, wb_tag);
        disp_hit1 = wb_match(disp_src1_tag, wb_valid, wb_tag);
    end

    // ------------------------------------------------------------------
    // Per-channel select. Each channel masks out entries already granted
    // to lower-numbered channels, so same-class channels pick the oldest,
    // second-oldest, ... ready entries.
    // ------------------------------------------------------------------
    for (genvar c = 0; c < NUM_FU; c++) begin : g_ch
        logic [DEPTH-1:0]        taken_in;
        logic [DEPTH-1:0]        taken_out;
        logic [DEPTH-1:0]        class_match;
        logic [DEPTH-1:0]        req;
        logic [DEPTH-1:0]        gnt;
        logic [OPCODE_WIDTH-1:0] op_mux;
        logic [PREG_WIDTH-1:0]   s0_mux;
        logic [PREG_WIDTH-1:0]   s1_mux;
        logic [PREG_WIDTH-1:0]   dst_mux;

        if (c == 0) begin : g_first
            assign taken_in = '0;
        end else begin : g_next
            assign taken_in = g_ch[c-1].taken_out;
        end

        always_comb begin
            for (int i = 0; i < DEPTH; i++) begin
                class_match[i] = (ent_q[i].fu == FU_CLASS[2*c +: 2]);
            end
        end

        // flush suppresses every grant, which also keeps the count update clean
        assign req = valid_vec & rdy0 & rdy1 & class_match & ~taken_in
                   & {DEPTH{fu_ready[c] & ~flush}};

        iq_age_select #(
            .DEPTH (DEPTH)
        ) u_age_select (
            .req   (req),
            .older (older_q),
            .gnt   (gnt)
        );

        assign taken_out = taken_in | gnt;

        // AND-OR payload mux; all-zero when nothing is granted
        always_comb begin
            op_mux  = '0;
            s0_mux  = '0;
            s1_mux  = '0;
            dst_mux = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (gnt[i]) begin
                    op_mux  = op_mux  | op_q[i];
                    s0_mux  = s0_mux  | src0_tag_q[i];
                    s1_mux  = s1_mux  | src1_tag_q[i];
                    dst_mux = dst_mux | dst_tag_q[i];
                end
            end
        end

        assign iss_valid[c]                                  = |gnt;
        assign iss_op[c*OPCODE_WIDTH +: OPCODE_WIDTH]        = op_mux;
        assign iss_src0_tag[c*PREG_WIDTH +: PREG_WIDTH]      = s0_mux;
        assign iss_src1_tag[c*PREG_WIDTH +: PREG_WIDTH]      = s1_mux;
        assign iss_dst_tag[c*PREG_WIDTH +: PREG_WIDTH]       = dst_mux;
    end

    // ------------------------------------------------------------------
    // Dispatch control and occupancy
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] issued;
    logic [DEPTH-1:0] free_oh;
    logic [CW-1:0]    n_issued;
    logic             accept;

    assign issued     = g_ch[NUM_FU-1].taken_out;
    // Registered count only: an entry leaving this cycle does not open a slot
    // until the next one.
    assign disp_ready = (count_q != FULL_CNT);
    assign accept     = disp_valid & disp_ready & ~flush;
    // Lowest clear bit of valid_vec: x & -x with x = ~valid_vec
    assign free_oh    = ~valid_vec & (valid_vec + DEPTH'(1));
    assign iq_count   = count_q;

    always_comb begin
        n_issued = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n_issued = n_issued + CW'(issued[i]);
        end
    end

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i]      <= '0;
                op_q[i]       <= '0;
                src0_tag_q[i] <= '0;
                src1_tag_q[i] <= '0;
                dst_tag_q[i]  <= '0;
            end
            older_q <= '0;
            count_q <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i].valid <= 1'b0;
            end
            older_q <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issued[i]) begin
                    ent_q[i].valid <= 1'b0;
                end
                if (hit0[i]) begin
                    ent_q[i].src0_rdy <= 1'b1;
                end
                if (hit1[i]) begin
                    ent_q[i].src1_rdy <= 1'b1;
                end
                // The new entry is younger than everything: clear its column
                // in every row, then its own row is rewritten below.
                if (accept) begin
                    older_q[i] <= older_q[i] & ~free_oh;
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (accept && free_oh[i]) begin
                    ent_q[i] <= '{valid:    1'b1,
                                  fu:       disp_fu,
                                  src0_rdy: disp_src0_rdy | disp_hit0,
                                  src1_rdy: disp_src1_rdy | disp_hit1};
                    op_q[i]       <= disp_op;
                    src0_tag_q[i] <= disp_src0_tag;
                    src1_tag_q[i] <= disp_src1_tag;
                    dst_tag_q[i]  <= disp_dst_tag;
                    older_q[i]    <= valid_vec & ~issued;
                end
            end
            count_q <= count_q + CW'(accept) - n_issued;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Testbench for issue_queue: directed scenarios plus random traffic, checked
// against an in-order list model through a scoreboard and a negedge monitor.
module tb_issue_queue;
    import iq_pkg::*;

    localparam int DEPTH  = 16;
    localparam int NUM_FU = 4;
    localparam int NUM_WB = 2;
    localparam int OW     = 7;
    localparam int PW     = 6;
    localparam int CW     = 5;
`ifdef IQ_SAME_CYCLE_WAKE_EN
    localparam bit SAME_WAKE = 1'b1;
`else
    localparam bit SAME_WAKE = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   flush = 1'b0;
    logic                   disp_valid = 1'b0;
    logic                   disp_ready;
    logic [1:0]             disp_fu = '0;
    logic [OW-1:0]          disp_op = '0;
    logic [PW-1:0]          disp_src0_tag = '0;
    logic [PW-1:0]          disp_src1_tag = '0;
    logic                   disp_src0_rdy = 1'b0;
    logic                   disp_src1_rdy = 1'b0;
    logic [PW-1:0]          disp_dst_tag = '0;
    logic [NUM_WB-1:0]      wb_valid = '0;
    logic [NUM_WB*PW-1:0]   wb_tag = '0;
    logic [NUM_FU-1:0]      fu_ready = '0;
    logic [NUM_FU-1:0]      iss_valid;
    logic [NUM_FU*OW-1:0]   iss_op;
    logic [NUM_FU*PW-1:0]   iss_src0_tag;
    logic [NUM_FU*PW-1:0]   iss_src1_tag;
    logic [NUM_FU*PW-1:0]   iss_dst_tag;
    logic [CW-1:0]          iq_count;

    always #5 clk = ~clk;

    issue_queue dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_fu       (disp_fu),
        .disp_op       (disp_op),
        .disp_src0_tag (disp_src0_tag),
        .disp_src1_tag (disp_src1_tag),
        .disp_src0_rdy (disp_src0_rdy),
        .disp_src1_rdy (disp_src1_rdy),
        .disp_dst_tag  (disp_dst_tag),
        .wb_valid      (wb_valid),
        .wb_tag        (wb_tag),
        .fu_ready      (fu_ready),
        .iss_valid     (iss_valid),
        .iss_op        (iss_op),
        .iss_src0_tag  (iss_src0_tag),
        .iss_src1_tag  (iss_src1_tag),
        .iss_dst_tag   (iss_dst_tag),
        .iq_count      (iq_count)
    );

    // Reference model: queue of entries kept in dispatch (age) order.
    typedef struct {
        logic [1:0]    fu;
        logic [OW-1:0] op;
        logic [PW-1:0] s0, s1, d;
        bit            r0, r1;
    } m_ent_t;

    typedef struct {
        logic [NUM_FU-1:0]         v;
        logic [NUM_FU-1:0][OW-1:0] op;
        logic [NUM_FU-1:0][PW-1:0] s0, s1, d;
        int                        cnt;
        bit                        rdy;
    } exp_t;

    logic [1:0] ch_cls [NUM_FU] = '{FU_ALU, FU_ALU, FU_MUL, FU_LS};
    m_ent_t mq[$];
    exp_t   sb[$];
    int     n_checks = 0;
    int     n_pass = 0;
    int     cyc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    endtask

    function automatic bit wb_hit(input logic [PW-1:0] t);
        for (int w = 0; w < NUM_WB; w++)
            if (wb_valid[w] && wb_tag[w*PW +: PW] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit eff_rdy(input bit r, input logic [PW-1:0] t);
        return r || (SAME_WAKE && wb_hit(t));
    endfunction

    // Predict this cycle's outputs from the model and current inputs, queue
    // them for the monitor, advance the model, then advance one clock.
    task automatic cycle();
        exp_t e;
        bit   taken [DEPTH];
        int   sz;
        m_ent_t n;
        sz = mq.size();
        e.v = '0; e.op = '0; e.s0 = '0; e.s1 = '0; e.d = '0;
        for (int k = 0; k < DEPTH; k++) taken[k] = 1'b0;
        for (int c = 0; c < NUM_FU; c++) begin
            if (!flush && fu_ready[c]) begin
                for (int k = 0; k < sz; k++) begin
                    if (!taken[k] && mq[k].fu == ch_cls[c] &&
                        eff_rdy(mq[k].r0, mq[k].s0) && eff_rdy(mq[k].r1, mq[k].s1)) begin
                        taken[k] = 1'b1;
                        e.v[c] = 1'b1; e.op[c] = mq[k].op;
                        e.s0[c] = mq[k].s0; e.s1[c] = mq[k].s1; e.d[c] = mq[k].d;
                        break;
                    end
                end
            end
        end
        e.cnt = sz;
        e.rdy = (sz != DEPTH);
        sb.push_back(e);
        if (flush) begin
            mq.delete();
        end else begin
            for (int k = sz - 1; k >= 0; k--) if (taken[k]) mq.delete(k);
            foreach (mq[k]) begin
                if (wb_hit(mq[k].s0)) mq[k].r0 = 1'b1;
                if (wb_hit(mq[k].s1)) mq[k].r1 = 1'b1;
            end
            if (disp_valid && sz != DEPTH) begin
                n.fu = disp_fu; n.op = disp_op; n.d = disp_dst_tag;
                n.s0 = disp_src0_tag; n.s1 = disp_src1_tag;
                n.r0 = disp_src0_rdy || wb_hit(disp_src0_tag);
                n.r1 = disp_src1_rdy || wb_hit(disp_src1_tag);
                mq.push_back(n);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        disp_valid = 1'b0; wb_valid = '0; flush = 1'b0;
    endtask

    task automatic disp(input logic [1:0] fu, input int op, input int s0, input bit r0,
                        input int s1, input bit r1);
        disp_valid = 1'b1; disp_fu = fu; disp_op = OW'(op);
        disp_src0_tag = PW'(s0); disp_src0_rdy = r0;
        disp_src1_tag = PW'(s1); disp_src1_rdy = r1;
        disp_dst_tag = PW'(op + 32);
    endtask

    task automatic wake(input int port, input int tag);
        wb_valid[port] = 1'b1;
        wb_tag[port*PW +: PW] = PW'(tag);
    endtask

    // Monitor: compare whatever the DUT presents against the next prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("iss_valid", iss_valid, e.v);
                for (int c = 0; c < NUM_FU; c++) begin
                    if (e.v[c]) begin
                        check("iss_op", iss_op[c*OW +: OW], e.op[c]);
                        check("iss_src0_tag", iss_src0_tag[c*PW +: PW], e.s0[c]);
                        check("iss_src1_tag", iss_src1_tag[c*PW +: PW], e.s1[c]);
                        check("iss_dst_tag", iss_dst_tag[c*PW +: PW], e.d[c]);
                    end
                end
                check("iq_count", iq_count, e.cnt);
                check("disp_ready", disp_ready, e.rdy);
            end
        end
    end

    initial begin
        @(posedge clk); #1;
        cycle();                      // outputs while held in reset
        rst_n = 1'b1;
        cycle();                      // idle after reset

        // Fill with 16 ready ALU ops, no channel ready; one extra is dropped.
        fu_ready = '0;
        for (int i = 0; i < DEPTH; i++) begin disp(FU_ALU, i, i, 1, i, 1); cycle(); end
        disp(FU_ALU, 99, 1, 1, 1, 1); cycle();
        // Two ALU channels drain in dispatch order over 8 cycles.
        idle(); fu_ready = 4'b0011;
        repeat (9) cycle();

        // MUL waiting on tag 5, woken at T.
        fu_ready = 4'b1111;
        disp(FU_MUL, 34, 5, 0, 1, 1); cycle();
        idle(); cycle();
        wake(0, 5); cycle();
        idle(); repeat (2) cycle();

        // Dispatch unready tag 9 while tag 9 is broadcast.
        disp(FU_ALU, 40, 9, 0, 2, 1); wake(1, 9); cycle();
        idle(); repeat (2) cycle();

        // LS A unready, LS B ready: B first, then A when woken.
        disp(FU_LS, 50, 20, 0, 3, 1); cycle();
        disp(FU_LS, 51, 4, 1, 3, 1); cycle();
        idle(); cycle();
        wake(0, 20); cycle();
        idle(); repeat (2) cycle();
        // With LS stalled: A2 (woken later) must still beat younger B2, C2.
        fu_ready = 4'b0111;
        disp(FU_LS, 60, 21, 0, 3, 1); cycle();
        disp(FU_LS, 61, 4, 1, 3, 1); cycle();
        idle(); wake(1, 21); cycle();
        idle(); disp(FU_LS, 62, 4, 1, 3, 1); cycle();
        idle(); fu_ready = 4'b1111;
        repeat (4) cycle();

        // Full queue with one entry issuing: the dispatch is refused that cycle.
        fu_ready = '0;
        for (int i = 0; i < DEPTH; i++) begin disp(FU_ALU, 70 + i, 1, 1, 1, 1); cycle(); end
        fu_ready = 4'b0001; disp(FU_ALU, 100, 1, 1, 1, 1); cycle();
        fu_ready = '0; disp(FU_ALU, 101, 1, 1, 1, 1); cycle();
        idle(); cycle();
        flush = 1'b1; cycle();
        idle(); cycle();

        // Flush with 7 entries and a dispatch pending.
        fu_ready = '0;
        for (int i = 0; i < 7; i++) begin disp(FU_ALU, 110 + i, 1, 1, 1, 1); cycle(); end
        fu_ready = 4'b1111; disp(FU_ALU, 120, 1, 1, 1, 1); flush = 1'b1; cycle();
        idle(); cycle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            fu_ready = NUM_FU'($urandom);
            flush = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) != 0)
                disp(2'($urandom), int'($urandom_range(0, 127)), int'($urandom_range(0, 15)),
                     bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                     bit'($urandom_range(0, 1)));
            else
                disp_valid = 1'b0;
            wb_valid = NUM_WB'($urandom);
            for (int w = 0; w < NUM_WB; w++) wb_tag[w*PW +: PW] = PW'($urandom_range(0, 15));
            cycle();
        end
        idle(); fu_ready = '0;
        repeat (2) cycle();

        @(negedge clk); #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
